// File: rtl/fir_mac_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : fir_mac_engine_if
//  Description : Sample, coefficient and result signals of the FIR MAC
//                engine. The master side is the sample source, the coefficient
//                loader and the result sink. The slave side is the engine.
//  Revision    : 1.0  initial release
// ============================================================================
interface fir_mac_engine_if #(
    parameter int WIDTH     = 16,
    parameter int TAPS_LOG2 = 6
);
    localparam int ACC_WIDTH = 2 * WIDTH + TAPS_LOG2;

    // Sample handshake
    logic signed [WIDTH-1:0]     FIR_input;
    logic                        input_valid;
    logic                        input_ready;

    // Coefficient write port
    logic                        coef_we;
    logic [TAPS_LOG2-1:0]        coef_addr;
    logic signed [WIDTH-1:0]     coef_data;

    // Result
    logic signed [ACC_WIDTH-1:0] FIR_output;
    logic                        output_valid;

    modport master (
        output FIR_input,
        output input_valid,
        input  input_ready,
        output coef_we,
        output coef_addr,
        output coef_data,
        input  FIR_output,
        input  output_valid
    );

    modport slave (
        input  FIR_input,
        input  input_valid,
        output input_ready,
        input  coef_we,
        input  coef_addr,
        input  coef_data,
        output FIR_output,
        output output_valid
    );
endinterface
`default_nettype wire

// File: rtl/fir_mac_engine.sv
`default_nettype none
// ============================================================================
//  Module      : fir_mac_engine
//  Description : Sequential single-multiplier FIR stage. It takes one sample
//                per handshake. It then walks all TAPS taps, one per clock, and
//                emits one accumulated result. Coefficients can be written only
//                while the engine is idle.
//  Revision    : 1.0  initial release
// ============================================================================
module fir_mac_engine #(
    parameter int WIDTH     = 16,
    parameter int TAPS_LOG2 = 6
) (
    input  wire logic        clock,
    input  wire logic        reset,
    fir_mac_engine_if.slave  bus
);
    localparam int TAPS       = 2 ** TAPS_LOG2;
    localparam int PROD_WIDTH = 2 * WIDTH;
    localparam int ACC_WIDTH  = 2 * WIDTH + TAPS_LOG2;
    localparam int EXT_WIDTH  = ACC_WIDTH - PROD_WIDTH;

    // The last tap is marked by an all-ones counter, so the counter simply
    // wraps back to zero as it leaves the last tap.
    localparam logic [TAPS_LOG2-1:0] c_LAST_TAP = '1;
    localparam logic [TAPS_LOG2-1:0] c_CNT_ONE  = TAPS_LOG2'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MAC  = 1'b1
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic                        w_ready;

    logic [TAPS_LOG2-1:0]        r_cnt;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [ACC_WIDTH-1:0] r_out;
    logic                        r_ovalid;

    logic signed [WIDTH-1:0]     r_x [TAPS];
    logic signed [WIDTH-1:0]     r_c [TAPS];

    logic                        w_accept;
    logic                        w_coef_wr;
    logic                        w_last;
    logic signed [WIDTH-1:0]     w_x_tap;
    logic signed [WIDTH-1:0]     w_c_tap;
    logic signed [PROD_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0] w_prod_ext;
    logic signed [ACC_WIDTH-1:0] w_sum;

    // A sample is accepted and a coefficient write is performed only in IDLE.
    // Both can happen on the same edge.
    assign w_accept  = (r_state == S_IDLE) && bus.input_valid;
    assign w_coef_wr = (r_state == S_IDLE) && bus.coef_we;
    assign w_last    = (r_state == S_MAC) && (r_cnt == c_LAST_TAP);

    // One shared multiplier and adder. The full-width product is sign-extended
    // into the accumulator. The extra TAPS_LOG2 guard bits make overflow
    // impossible, so no saturation is needed.
    assign w_x_tap    = r_x[r_cnt];
    assign w_c_tap    = r_c[r_cnt];
    assign w_prod     = $signed(PROD_WIDTH'(w_x_tap)) * $signed(PROD_WIDTH'(w_c_tap));
    assign w_prod_ext = {{EXT_WIDTH{w_prod[PROD_WIDTH-1]}}, w_prod};
    assign w_sum      = r_acc + w_prod_ext;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and ready decode
    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.input_valid) begin
                    w_state_next = S_MAC;
                end
            end
            S_MAC: begin
                if (r_cnt == c_LAST_TAP) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Tap counter and accumulator: clear on accept, then one MAC per cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (r_state == S_MAC) begin
            r_cnt <= r_cnt + c_CNT_ONE;
            r_acc <= w_sum;
        end
    end

    // Sample history shift register: x[0] holds the newest accepted sample
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                r_x[k] <= '0;
            end
        end else if (w_accept) begin
            for (int k = TAPS - 1; k > 0; k--) begin
                r_x[k] <= r_x[k-1];
            end
            r_x[0] <= bus.FIR_input;
        end
    end

    // Coefficient bank. Writes during MAC are dropped, so a result always
    // comes from one consistent set of coefficients.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                r_c[k] <= '0;
            end
        end else if (w_coef_wr) begin
            r_c[bus.coef_addr] <= bus.coef_data;
        end
    end

    // Result register and one-cycle valid pulse on the last-tap edge
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out    <= '0;
            r_ovalid <= 1'b0;
        end else begin
            r_ovalid <= w_last;
            if (w_last) begin
                r_out <= w_sum;
            end
        end
    end

    assign bus.input_ready  = w_ready;
    assign bus.FIR_output   = r_out;
    assign bus.output_valid = r_ovalid;

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_mac_engine
//  Description : Self-checking bench for fir_mac_engine. A behavioural model
//                forms each result as a dot product over the sample history
//                when the sample is accepted. It then schedules that result
//                TAPS cycles later. Randomised and directed stimulus are used.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fir_mac_engine;
    localparam int WIDTH     = 16;
    localparam int TAPS_LOG2 = 6;
    localparam int TAPS      = 64;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    fir_mac_engine_if #(.WIDTH(WIDTH), .TAPS_LOG2(TAPS_LOG2)) bus ();

    fir_mac_engine #(.WIDTH(WIDTH), .TAPS_LOG2(TAPS_LOG2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint m_x [TAPS];
    longint m_c [TAPS];
    longint m_pending = 0;
    longint m_out     = 0;
    bit     m_valid   = 1'b0;
    bit     m_busy    = 1'b0;
    int     m_left    = 0;
    int     cyc       = 0;
    int     m_accepts = 0;
    int     m_acc_cyc = 0;

    always @(posedge clock) begin
        longint s;
        cyc++;
        m_valid = 1'b0;
        if (reset) begin
            foreach (m_x[k]) begin m_x[k] = 0; m_c[k] = 0; end
            m_out  = 0;
            m_busy = 1'b0;
            m_left = 0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy  = 1'b0;
                m_valid = 1'b1;
                m_out   = m_pending;
            end
        end else begin
            if (bus.coef_we) m_c[bus.coef_addr] = longint'(bus.coef_data);
            if (bus.input_valid) begin
                for (int k = TAPS - 1; k > 0; k--) m_x[k] = m_x[k-1];
                m_x[0] = longint'(bus.FIR_input);
                s = 0;
                for (int k = 0; k < TAPS; k++) s += m_x[k] * m_c[k];
                m_pending = s;
                m_busy    = 1'b1;
                m_left    = TAPS;
                m_accepts++;
                m_acc_cyc = cyc;
            end
        end
    end

    // ---------------- per-cycle compare and result capture ----------------
    longint got_q[$];
    int     got_cyc_q[$];

    always @(negedge clock) begin
        check("input_ready",  64'(bus.input_ready),  64'(!m_busy));
        check("output_valid", 64'(bus.output_valid), 64'(m_valid));
        check("FIR_output",   64'(bus.FIR_output),   m_out);
        if (bus.output_valid === 1'b1) begin
            got_q.push_back(longint'(bus.FIR_output));
            got_cyc_q.push_back(cyc);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic signed [WIDTH-1:0] v);
        int start;
        start = m_accepts;
        bus.FIR_input   = v;
        bus.input_valid = 1'b1;
        for (int i = 0; i < 300 && m_accepts == start; i++) tick();
        if (m_accepts == start) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept, expected accept within 300 cycles");
        end
        bus.input_valid = 1'b0;
    endtask

    task automatic write_coef(input int addr, input logic signed [WIDTH-1:0] data);
        bus.coef_we   = 1'b1;
        bus.coef_addr = TAPS_LOG2'(addr);
        bus.coef_data = data;
        tick();
        bus.coef_we   = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && m_busy; i++) tick();
        tick();
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1;
        int a2;
        bus.FIR_input   = 16'sd9;
        bus.input_valid = 1'b1;
        bus.coef_we     = 1'b0;
        bus.coef_addr   = '0;
        bus.coef_data   = '0;

        // Reset held two edges with input_valid high
        tick();
        tick();
        check("rst_ready",  64'(bus.input_ready), 64'd1);
        check("rst_out",    64'(bus.FIR_output),  64'd0);
        reset           = 1'b0;
        bus.input_valid = 1'b0;
        tick();
        check("post_rst_ready", 64'(bus.input_ready), 64'd1);

        // Impulse through c[k] = k+1
        for (int k = 0; k < TAPS; k++) write_coef(k, 16'(k + 1));
        got_q.delete();
        got_cyc_q.delete();
        send(16'sd1);
        a1 = m_acc_cyc;
        for (int k = 0; k < TAPS; k++) send(16'sd0);
        wait_idle();
        check("impulse_count", 64'(got_q.size()), 64'd65);
        if (got_q.size() == 65) begin
            for (int j = 0; j < TAPS; j++) check("impulse_val", got_q[j], longint'(j + 1));
            check("impulse_tail", got_q[64], 0);
            check("impulse_latency", 64'(got_cyc_q[0] - a1), 64'd64);
            check("impulse_spacing", 64'(got_cyc_q[1] - got_cyc_q[0]), 64'd65);
        end

        // Handshake stall: sample 5 held during MAC
        got_q.delete();
        got_cyc_q.delete();
        send(16'sd10);
        a1 = m_acc_cyc;
        send(16'sd5);
        a2 = m_acc_cyc;
        wait_idle();
        check("stall_accept_gap", 64'(a2 - a1), 64'd65);
        if (got_cyc_q.size() == 2) begin
            check("stall_valid_cycle", 64'(got_cyc_q[0]), 64'(a1 + 64));
            check("stall_next_valid",  64'(got_cyc_q[1]), 64'(a2 + 64));
        end else begin
            check("stall_count", 64'(got_cyc_q.size()), 64'd2);
        end

        // Coefficient write during MAC is dropped
        for (int k = 0; k < TAPS; k++) write_coef(k, 16'sd1);
        for (int k = 0; k < TAPS; k++) send(16'sd2);
        wait_idle();
        check("primed_sum", got_q[$], 128);
        got_q.delete();
        send(16'sd3);
        for (int i = 0; i < 10; i++) tick();
        write_coef(3, 16'sd100);
        wait_idle();
        send(16'sd4);
        wait_idle();
        if (got_q.size() == 2) begin
            check("midmac_write_cur",  got_q[0], 129);
            check("midmac_write_next", got_q[1], 131);
        end else begin
            check("midmac_count", 64'(got_q.size()), 64'd2);
        end

        // Extremes
        for (int k = 0; k < TAPS; k++) write_coef(k, -16'sd32768);
        for (int k = 0; k < TAPS; k++) send(-16'sd32768);
        wait_idle();
        check("extreme_sum", got_q[$], 64'sd68719476736);

        // Randomised traffic, coefficient writes in every state
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                bus.coef_we   = 1'($urandom);
                bus.coef_addr = TAPS_LOG2'($urandom);
                bus.coef_data = 16'($urandom);
                tick();
            end
            bus.coef_we   = 1'($urandom);
            bus.coef_addr = TAPS_LOG2'($urandom);
            bus.coef_data = 16'($urandom);
            send(16'($urandom));
            bus.coef_we = 1'b0;
            if ($urandom_range(0, 3) == 0) wait_idle();
        end
        wait_idle();

        // Reset mid-MAC
        write_coef(0, 16'sd1);
        got_q.delete();
        send(16'sd7);
        for (int i = 0; i < 20; i++) tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("midrst_ready", 64'(bus.input_ready), 64'd1);
        check("midrst_out",   64'(bus.FIR_output),  64'd0);
        for (int i = 0; i < 60; i++) tick();
        check("midrst_no_pulse", 64'(got_q.size()), 64'd0);
        send(16'sd1);
        wait_idle();
        check("midrst_impulse_count", 64'(got_q.size()), 64'd1);
        if (got_q.size() == 1) check("midrst_impulse_val", got_q[0], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
